request_fifo_reader: RTL
========================

# request_fifo_reader

Consumer end of the request FIFO that the index extractor fills with 128-bit packed AXI read/write requests. Pops entries from a synchronous-read FIFO, unpacks direction, ID, address and slave fields, and splits the address into DRAM-cache tag/index/offset. Presents each request downstream on a valid/ready handshake. A two-entry buffer keeps full throughput under backpressure.

## Interface
- DATA_W, 128, FIFO entry width
- ID_W, 32, request ID width
- ADDR_W, 32, request address width
- OFFSET_W, 6, line-offset bits (64 B lines)
- INDEX_W, 12, cache-set index bits; tag width = ADDR_W - INDEX_W - OFFSET_W (14 by default)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- fifo_empty  in  1  FIFO holds no entries
- fifo_read_enable  out  1  pop request; data appears on fifo_o next cycle
- fifo_o  in  DATA_W  FIFO read data
- req_valid_o  out  1  request presented
- req_ready_i  in  1  downstream accepts
- req_wr_o  out  1  1 = write (AW), 0 = read (AR)
- req_id_o  out  ID_W  request ID
- req_addr_o  out  ADDR_W  full address
- req_tag_o  out  ADDR_W-INDEX_W-OFFSET_W  address tag field
- req_index_o  out  INDEX_W  set index
- req_offset_o  out  OFFSET_W  line offset
- req_slave_o  out  4  target slave number
- rd_count_o  out  16  accepted read requests, wraps
- wr_count_o  out  16  accepted write requests, wraps

## Operation
- Entry format: [127:101] reserved (ignored); [100] wr; [99:96] slave; [95:64] id; [63:32] addr; [31:0] reserved.
- Address split: offset = addr[OFFSET_W-1:0]; index = addr[OFFSET_W+INDEX_W-1:OFFSET_W]; tag = remaining upper bits.
- Buffer: two-entry queue, head drives outputs. occ ∈ {0,1,2}. inflight = 1 while a pop issued last cycle has not yet been captured.
- pop = req_valid_o & req_ready_i.
- fifo_read_enable = !fifo_empty & (occ + inflight - pop < 2). This is combinational from fifo_empty and req_ready_i.
- Capture: when inflight is 1, fifo_o is written into the queue tail. If pop happens in the same cycle, the head advances first. A capture into an empty queue, or into a queue that becomes empty on the pop, becomes the new head.
- req_valid_o = (occ != 0). This is registered state; there is no combinational path from fifo_o.
- Head fields are stable while req_valid_o & !req_ready_i.
- Order is strict FIFO. No reordering across slaves or directions.
- Counters: rd_count_o or wr_count_o increments by 1 on each pop, selected by the head wr bit. Wraps 0xFFFF -> 0x0000.
- Reset (any time): occ = 0 and inflight = 0. An in-flight entry is discarded; the FIFO is reset by the same rst.

## Timing
- Reset values: fifo_read_enable 0 while rst is high; req_valid_o 0; all req_* data outputs 0; both counters 0.
- Latency: fifo_read_enable high in cycle N -> capture at end of N+1 -> req_valid_o high in N+2.
- Steady state with req_ready_i held high: one request per cycle, no bubbles.
- Backpressure: with req_ready_i low, at most 2 entries are buffered. Once occ + inflight reaches 2, fifo_read_enable stays 0.
- Simultaneous capture and pop with occ = 2 cannot occur: it is prevented by the read rule.
- fifo_empty high: fifo_read_enable stays 0, and buffered entries still drain.

## Test plan
- Single read: FIFO entry wr=0, slave=3, id=1, addr=100 (0x64).
  - fifo_read_enable pulses once.
  - Two cycles later: req_valid_o = 1, req_id_o = 1, req_addr_o = 100, offset = 36, index = 1, tag = 0, slave = 3.
  - After accept, rd_count_o = 1.
- Streaming: 4 entries queued, req_ready_i held high.
  - req_valid_o high for 4 consecutive cycles.
  - IDs 1, 2, 3, 4 appear in order, with no bubbles.
- Backpressure: 4 entries queued, req_ready_i low for 10 cycles.
  - Exactly 2 pops occur, then fifo_read_enable stays 0.
  - Head (id 1) is stable throughout.
  - Releasing req_ready_i delivers ids 1–4 in order.
- Mixed directions: alternate wr = 0/1 across 6 entries, all accepted.
  - rd_count_o = 3 and wr_count_o = 3.
  - req_wr_o matches each entry.
- Reset mid-flight: assert rst in the cycle after fifo_read_enable.
  - req_valid_o = 0 and counters = 0 immediately.
  - No stale request appears after rst deasserts.
- Counter wrap: preload 65535 accepted reads.
  - The next read brings rd_count_o to 0.

Source files
------------

// File: rtl/request_fifo_reader.sv
// Consumer side of the packed AXI request FIFO: pops entries, unpacks them and
// presents them on a valid/ready port through a two-entry skid queue.
module request_fifo_reader #(
  parameter int DATA_W   = 128,
  parameter int ID_W     = 32,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 12
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              fifo_empty,
  output logic                              fifo_read_enable,
  input  logic [DATA_W-1:0]                 fifo_o,
  output logic                              req_valid_o,
  input  logic                              req_ready_i,
  output logic                              req_wr_o,
  output logic [ID_W-1:0]                   req_id_o,
  output logic [ADDR_W-1:0]                 req_addr_o,
  output logic [ADDR_W-INDEX_W-OFFSET_W-1:0] req_tag_o,
  output logic [INDEX_W-1:0]                req_index_o,
  output logic [OFFSET_W-1:0]               req_offset_o,
  output logic [3:0]                        req_slave_o,
  output logic [15:0]                       rd_count_o,
  output logic [15:0]                       wr_count_o
);

  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int ENT_W    = 1 + 4 + ID_W + ADDR_W;
  localparam int ADDR_LSB = 32;
  localparam int ID_LSB   = 64;
  localparam int SLV_LSB  = 96;
  localparam int WR_BIT   = 100;

  logic [ENT_W-1:0] r_buf [2];
  logic [1:0]       r_occ;
  logic             r_inflight;
  logic [15:0]      r_rd_cnt;
  logic [15:0]      r_wr_cnt;

  logic [ENT_W-1:0] w_entry;
  logic [ENT_W-1:0] w_head;
  logic             w_pop;
  logic [2:0]       w_level;
  logic [1:0]       w_occ_after_pop;
  logic [1:0]       w_occ_next;
  logic             w_slot;
  logic             w_unused_bits;

  assign w_entry = {fifo_o[WR_BIT], fifo_o[SLV_LSB +: 4], fifo_o[ID_LSB +: ID_W],
                    fifo_o[ADDR_LSB +: ADDR_W]};
  assign w_unused_bits = ^{fifo_o[DATA_W-1:WR_BIT+1], fifo_o[ADDR_LSB-1:0]};

  assign w_head = r_buf[0];
  assign w_pop  = req_valid_o & req_ready_i;

  // Level counts the entry already requested but not yet captured, so the
  // queue can never be asked to hold a third entry.
  assign w_level          = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign fifo_read_enable = !rst & !fifo_empty & (w_level < 3'd2);

  assign w_occ_after_pop = r_occ - {1'b0, w_pop};
  assign w_occ_next      = w_occ_after_pop + {1'b0, r_inflight};
  assign w_slot          = w_occ_after_pop[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_rd_cnt   <= 16'd0;
      r_wr_cnt   <= 16'd0;
    end else begin
      r_inflight <= fifo_read_enable;
      r_occ      <= w_occ_next;
      if (w_pop) begin
        r_buf[0] <= r_buf[1];
        if (w_head[ENT_W-1]) r_wr_cnt <= r_wr_cnt + 16'd1;
        else                 r_rd_cnt <= r_rd_cnt + 16'd1;
      end
      // Capture lands after the head shift; it overrides the shift when it targets slot 0.
      if (r_inflight) r_buf[w_slot] <= w_entry;
    end
  end

  assign req_valid_o  = (r_occ != 2'd0);
  assign req_wr_o     = w_head[ENT_W-1];
  assign req_slave_o  = w_head[ID_W+ADDR_W +: 4];
  assign req_id_o     = w_head[ADDR_W +: ID_W];
  assign req_addr_o   = w_head[ADDR_W-1:0];
  assign req_offset_o = req_addr_o[OFFSET_W-1:0];
  assign req_index_o  = req_addr_o[OFFSET_W +: INDEX_W];
  assign req_tag_o    = req_addr_o[ADDR_W-1 -: TAG_W];
  assign rd_count_o   = r_rd_cnt;
  assign wr_count_o   = r_wr_cnt;

endmodule
